// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the FPU-side float/integer blocks:
//                binary32 field widths, exponent bias, int32 saturation
//                limits, converter state encoding and the unpacked-float
//                field struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Converter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLASS = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // binary32 split into its three fields, MSB first so that a raw
    // 32-bit word can be assigned directly
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_fields_t;

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_unpack
//  Description : Combinational binary32 unpacker. Splits a word into
//                sign/exponent/fraction, produces the unbiased exponent and
//                classifies zero/denormal, infinity and NaN.
//  Ports       : i_operand        - binary32 word
//                o_fields         - {sign, exp, frac}
//                o_exp_unb        - exp - BIAS, signed (-127 .. 128)
//                o_is_zero_denorm - exp == 0
//                o_is_inf         - exp all ones, frac == 0
//                o_is_nan         - exp all ones, frac != 0
//  Revision    : 1.0 - initial release
// ============================================================================
import fp_pkg::*;

module fp_unpack (
    input  logic [31:0]       i_operand,
    output fp_fields_t        o_fields,
    output logic signed [9:0] o_exp_unb,
    output logic              o_is_zero_denorm,
    output logic              o_is_inf,
    output logic              o_is_nan
);

    localparam logic signed [9:0] c_bias = 10'(BIAS);

    logic w_exp_max;
    logic w_frac_nz;

    assign o_fields  = i_operand;
    assign w_exp_max = &o_fields.exp;
    assign w_frac_nz = |o_fields.frac;

    assign o_exp_unb        = $signed({2'b00, o_fields.exp}) - c_bias;
    assign o_is_zero_denorm = (o_fields.exp == '0);
    assign o_is_inf         = w_exp_max & ~w_frac_nz;
    assign o_is_nan         = w_exp_max &  w_frac_nz;

endmodule
`default_nettype wire

// File: rtl/fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_int
//  Description : Sequential binary32 -> signed int32 converter with
//                valid/ready handshakes. The significand is aligned one bit
//                position per cycle, then truncated or rounded to nearest
//                even, then signed.
//  Ports       : CLK       - clock, rising edge
//                RSTn      - asynchronous active-low reset
//                InValid   - Operand presented
//                InReady   - converter idle and able to accept
//                Operand   - binary32 input
//                RoundMode - 0 truncate, 1 round-to-nearest-even
//                OutValid  - Result and flags valid
//                OutReady  - consumer takes the result
//                Result    - signed 32-bit integer
//                Invalid   - NaN or infinity input
//                Overflow  - finite magnitude outside int32
//                Inexact   - nonzero fraction bits discarded
//  Revision    : 1.0 - initial release
// ============================================================================
import fp_pkg::*;

module fp_to_int (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Operand,
    input  logic        RoundMode,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        Invalid,
    output logic        Overflow,
    output logic        Inexact
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_operand;
    logic        r_round_mode;
    logic [31:0] r_acc;        // aligned magnitude
    logic        r_guard;      // first bit below the binary point
    logic        r_sticky;     // OR of all bits below the guard
    logic [4:0]  r_cnt;        // remaining shift positions
    logic        r_left;       // shift direction
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_overflow;
    logic        r_inexact;
    logic        r_out_valid;

    // ------------------------------------------------------------------
    // Classification of the captured operand
    // ------------------------------------------------------------------
    fp_fields_t        w_fields;
    logic signed [9:0] w_e;
    logic              w_is_zd;
    logic              w_is_inf;
    logic              w_is_nan;

    fp_unpack u_unpack (
        .i_operand        (r_operand),
        .o_fields         (w_fields),
        .o_exp_unb        (w_e),
        .o_is_zero_denorm (w_is_zd),
        .o_is_inf         (w_is_inf),
        .o_is_nan         (w_is_nan)
    );

    logic        w_tiny;       // |x| < 0.5 and normal
    logic        w_ovf;
    logic        w_right;
    logic [4:0]  w_n;
    logic [23:0] w_mant;

    // e < -1 is the same as exp < BIAS-1
    assign w_tiny  = (w_fields.exp < 8'(BIAS - 1));
    // e = 31 is representable only as exactly -2^31
    assign w_ovf   = (w_e >= 10'sd31) &&
                     !(w_fields.sign && (w_e == 10'sd31) && (w_fields.frac == '0));
    assign w_right = (w_e < 10'sd23);
    // Only taken for -1 <= e <= 31, so modulo-32 arithmetic on the low
    // exponent bits gives |e - 23| directly.
    assign w_n     = w_right ? (5'd23 - w_e[4:0]) : (w_e[4:0] - 5'd23);
    assign w_mant  = {1'b1, w_fields.frac};

    // ------------------------------------------------------------------
    // Rounding and sign application
    // ------------------------------------------------------------------
    logic        w_round_up;
    logic [31:0] w_mag;

    assign w_round_up = r_round_mode & r_guard & (r_sticky | r_acc[0]);
    assign w_mag      = r_acc + {31'd0, w_round_up};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= ST_IDLE;
            r_operand    <= '0;
            r_round_mode <= 1'b0;
            r_acc        <= '0;
            r_guard      <= 1'b0;
            r_sticky     <= 1'b0;
            r_cnt        <= '0;
            r_left       <= 1'b0;
            r_result     <= '0;
            r_invalid    <= 1'b0;
            r_overflow   <= 1'b0;
            r_inexact    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        r_operand    <= Operand;
                        r_round_mode <= RoundMode;
                        r_result     <= '0;
                        r_invalid    <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_inexact    <= 1'b0;
                        r_state      <= ST_CLASS;
                    end
                end

                ST_CLASS: begin
                    r_acc    <= {8'd0, w_mant};
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                    r_cnt    <= w_n;
                    r_left   <= ~w_right;
                    if (w_is_inf || w_is_nan) begin
                        r_invalid <= 1'b1;
                        r_result  <= (w_is_inf && w_fields.sign) ? INT_MIN : INT_MAX;
                        r_state   <= ST_DONE;
                    end else if (w_is_zd) begin
                        r_result  <= '0;
                        r_inexact <= |w_fields.frac;
                        r_state   <= ST_DONE;
                    end else if (w_tiny) begin
                        r_result  <= '0;
                        r_inexact <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_ovf) begin
                        r_overflow <= 1'b1;
                        r_result   <= w_fields.sign ? INT_MIN : INT_MAX;
                        r_state    <= ST_DONE;
                    end else if (w_n == 5'd0) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (r_left) begin
                        r_acc <= {r_acc[30:0], 1'b0};
                    end else begin
                        r_acc    <= {1'b0, r_acc[31:1]};
                        r_guard  <= r_acc[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= ST_ROUND;
                    end
                end

                ST_ROUND: begin
                    // Inexact paths have e <= 22, so the increment never
                    // carries out of int32 range.
                    r_inexact <= r_guard | r_sticky;
                    r_result  <= w_fields.sign ? (~w_mag + 32'd1) : w_mag;
                    r_state   <= ST_DONE;
                end

                ST_DONE: begin
                    // Result and flags are already settled on entry; the
                    // valid flag is raised one cycle later from a register
                    // and dropped on the consuming edge.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (OutReady) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign InReady  = (r_state == ST_IDLE);
    assign OutValid = r_out_valid;
    assign Result   = r_result;
    assign Invalid  = r_invalid;
    assign Overflow = r_overflow;
    assign Inexact  = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_to_int
//  Description : Self-checking bench for fp_to_int. Directed cases plus
//                randomized operands compared against an arithmetic model
//                of float-to-integer conversion (quotient/remainder form).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_int;

    logic        CLK       = 1'b0;
    logic        RSTn      = 1'b0;
    logic        InValid   = 1'b0;
    logic [31:0] Operand   = '0;
    logic        RoundMode = 1'b0;
    logic        OutReady  = 1'b0;
    logic        InReady;
    logic        OutValid;
    logic [31:0] Result;
    logic        Invalid;
    logic        Overflow;
    logic        Inexact;

    int n_checks = 0;
    int n_errors = 0;

    fp_to_int dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .InValid   (InValid),
        .InReady   (InReady),
        .Operand   (Operand),
        .RoundMode (RoundMode),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .Invalid   (Invalid),
        .Overflow  (Overflow),
        .Inexact   (Inexact)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: value = mant * 2^(e-23); integer part and remainder are
    // formed with plain shifts, then rounding compares the remainder to 1/2.
    function automatic void model(input logic [31:0] op, input logic rm,
                                  output logic [31:0] res, output logic [2:0] flags,
                                  output int lat);
        logic        sgn;
        logic [7:0]  ex;
        logic [22:0] fr;
        int          e;
        int          s;
        longint      mant, q, r, half, mag;
        logic        inv, ovf, inx;
        sgn = op[31];
        ex  = op[30:23];
        fr  = op[22:0];
        e   = int'(ex) - 127;
        inv = 1'b0; ovf = 1'b0; inx = 1'b0;
        mag = 0;
        res = 32'd0;
        lat = 2;
        if (ex == 8'hFF) begin
            inv = 1'b1;
            res = (sgn && fr == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (ex == 8'h00) begin
            inx = (fr != 0);
        end else if (e < -1) begin
            inx = 1'b1;
        end else begin
            mant = longint'({1'b1, fr});
            if (e >= 31 && !(sgn && e == 31 && fr == 0)) begin
                ovf = 1'b1;
                res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                if (e >= 23) begin
                    mag = mant << (e - 23);
                    lat = 3 + (e - 23);
                end else begin
                    s    = 23 - e;
                    q    = mant >> s;
                    r    = mant - (q << s);
                    half = longint'(1) << (s - 1);
                    inx  = (r != 0);
                    if (rm && (r > half || (r == half && q[0])))
                        q = q + 1;
                    mag = q;
                    lat = 3 + s;
                end
                res = sgn ? 32'(-mag) : 32'(mag);
            end
        end
        flags = {inv, ovf, inx};
    endfunction

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (InReady !== 1'b1 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    // One full transaction: accept, measure latency, compare, consume.
    task automatic run_conv(input logic [31:0] op, input logic rm, input logic early,
                            input string tag);
        logic [31:0] er;
        logic [2:0]  ef;
        int          el;
        int          cyc;
        model(op, rm, er, ef, el);
        wait_ready();
        Operand   = op;
        RoundMode = rm;
        InValid   = 1'b1;
        OutReady  = early;
        @(posedge CLK); #1;
        InValid   = 1'b0;
        Operand   = $urandom;
        RoundMode = 1'($urandom);
        cyc = 0;
        while (OutValid !== 1'b1 && cyc < 60) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(el));
        check({tag, "/result"}, Result, er);
        check({tag, "/flags"}, {29'd0, Invalid, Overflow, Inexact}, {29'd0, ef});
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
        check({tag, "/taken"}, {30'd0, OutValid, InReady}, 32'd1);
    endtask

    initial begin
        logic [31:0] op;
        logic [7:0]  ex;
        int          cyc;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset/ctrl", {27'd0, InReady, OutValid, Invalid, Overflow, Inexact}, 32'h10);
        check("reset/result", Result, 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Directed cases
        run_conv(32'h4148_0000, 1'b0, 1'b0, "12.5/trunc");
        run_conv(32'h4148_0000, 1'b1, 1'b0, "12.5/rne");
        run_conv(32'h4158_0000, 1'b1, 1'b0, "13.5/rne");
        run_conv(32'hBF80_0000, 1'b0, 1'b0, "-1.0");
        run_conv(32'h4B80_0000, 1'b0, 1'b0, "2^24");
        run_conv(32'h4B00_0000, 1'b1, 1'b0, "2^23");
        run_conv(32'h4F00_0000, 1'b0, 1'b0, "2^31");
        run_conv(32'hCF00_0000, 1'b0, 1'b0, "-2^31");
        run_conv(32'hCF00_0001, 1'b1, 1'b0, "-2^31-ulp");
        run_conv(32'h7FC0_0000, 1'b0, 1'b0, "nan");
        run_conv(32'hFF80_0000, 1'b0, 1'b0, "-inf");
        run_conv(32'h3F40_0000, 1'b1, 1'b0, "0.75/rne");
        run_conv(32'h3F40_0000, 1'b0, 1'b0, "0.75/trunc");
        run_conv(32'h3F00_0000, 1'b1, 1'b0, "0.5/rne");
        run_conv(32'h0000_0001, 1'b0, 1'b0, "denorm");
        run_conv(32'h8000_0000, 1'b1, 1'b0, "-zero");
        run_conv(32'h3E80_0000, 1'b1, 1'b0, "0.25");
        run_conv(32'hC158_0000, 1'b1, 1'b1, "-13.5/early_ready");

        // Result held while the consumer stalls; busy inputs are ignored
        wait_ready();
        Operand   = 32'h4148_0000;
        RoundMode = 1'b0;
        InValid   = 1'b1;
        @(posedge CLK); #1;
        Operand   = 32'h3F80_0000;
        cyc = 0;
        while (OutValid !== 1'b1 && cyc < 60) begin
            @(posedge CLK); #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("stall/result", Result, 32'd12);
            check("stall/ctrl", {30'd0, OutValid, InReady}, 32'd2);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("stall/not_captured", {30'd0, OutValid, InReady}, 32'd1);
        end

        // Reset in the middle of the shift phase
        Operand   = 32'h4148_0000;
        RoundMode = 1'b1;
        InValid   = 1'b1;
        @(posedge CLK); #1;
        InValid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("midreset/busy", {31'd0, InReady}, 32'd0);
        RSTn = 1'b0;
        #1;
        check("midreset/ctrl", {27'd0, InReady, OutValid, Invalid, Overflow, Inexact}, 32'h10);
        check("midreset/result", Result, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (OutValid !== 1'b0 || InReady !== 1'b1)
                check("midreset/idle", {30'd0, OutValid, InReady}, 32'd1);
        end
        check("midreset/idle_end", {30'd0, OutValid, InReady}, 32'd1);
        run_conv(32'h4158_0000, 1'b0, 1'b0, "after_reset");

        // Randomized operands, biased towards the interesting exponents
        for (int i = 0; i < 200; i++) begin
            op = $urandom;
            case (i % 4)
                0: ex = op[30:23];
                1: ex = 8'(126 + $urandom_range(0, 32));
                2: ex = 8'(100 + $urandom_range(0, 50));
                default: ex = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            endcase
            op[30:23] = ex;
            if (i % 16 == 3) op[22:0] = '0;
            run_conv(op, 1'($urandom), 1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
